// File: rtl/mac_tile_cfg.sv
// Dual-mode (weight-stationary / output-stationary) systolic-array PE with
// configurable widths, kernel size, optional ReLU and a two-bank OFIFO drain.
module mac_tile_cfg #(
  parameter int bw       = 4,
  parameter int psum_bw  = 16,
  parameter int acc_kij  = 9,
  parameter int input_ch = 3,
  parameter int relu_en  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [bw-1:0]      in_w,
  input  logic [psum_bw-1:0] in_n,
  input  logic [1:0]         inst_w,
  output logic [bw-1:0]      out_e,
  output logic [1:0]         inst_e,
  output logic [psum_bw-1:0] out_s,
  output logic               ififo_loop,
  output logic [psum_bw-1:0] os_out,
  output logic               os_out_valid,
  input  logic               os_out_ready,
  output logic               out_stall
);

  localparam int N  = acc_kij * input_ch;
  localparam int CW = $clog2(N + 1);
  localparam int KW = $clog2(acc_kij + 1);

  logic [bw-1:0]      a_q, b_q;
  logic [psum_bw-1:0] c_q, acc;
  logic [1:0]         inst_q;
  logic               load_ready, pv;
  logic [CW-1:0]      cnt;
  logic [KW-1:0]      kcnt;
  logic [psum_bw-1:0] bank [2];
  logic [1:0]         full;
  logic               head, tail;

  logic [psum_bw-1:0] a_ext, b_ext, prod, sum, result;
  logic               step, last_prod, bank_wr, xfer;

  // Unsigned activation times signed weight; low psum_bw bits are exact mod 2^psum_bw.
  always_comb begin
    a_ext  = {{(psum_bw-bw){1'b0}}, a_q};
    b_ext  = {{(psum_bw-bw){b_q[bw-1]}}, b_q};
    prod   = a_ext * b_ext;
    sum    = acc + prod;
    result = ((relu_en != 0) && sum[psum_bw-1]) ? '0 : sum;
  end

  assign step      = mode && inst_w[1] && !out_stall;
  assign last_prod = (cnt == CW'(N - 1));
  assign bank_wr   = pv && last_prod;
  assign xfer      = os_out_valid && os_out_ready;

  assign out_e        = a_q;
  assign inst_e       = inst_q;
  assign out_s        = mode ? {{(psum_bw-bw){1'b0}}, b_q} : prod + c_q;
  assign ififo_loop   = pv && (kcnt == KW'(acc_kij - 1));
  assign os_out_valid = full[head];
  assign os_out       = os_out_valid ? bank[head] : '0;
  assign out_stall    = &full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q        <= '0;
      b_q        <= '0;
      c_q        <= '0;
      acc        <= '0;
      inst_q     <= '0;
      load_ready <= 1'b1;
      pv         <= 1'b0;
      cnt        <= '0;
      kcnt       <= '0;
      bank[0]    <= '0;
      bank[1]    <= '0;
      full       <= '0;
      head       <= 1'b0;
      tail       <= 1'b0;
    end else begin
      inst_q[1] <= inst_w[1];
      if (!mode) begin
        c_q <= in_n;
        if (inst_w != 2'b00) a_q <= in_w;
        if (inst_w[0] && load_ready) begin
          b_q        <= in_w;
          load_ready <= 1'b0;
        end
        // First load word is consumed locally; later ones travel east.
        if (!load_ready) inst_q[0] <= inst_w[0];
        pv   <= 1'b0;
        acc  <= '0;
        cnt  <= '0;
        kcnt <= '0;
      end else begin
        pv <= step;
        if (step) begin
          a_q <= in_w;
          b_q <= in_n[bw-1:0];
        end
        if (pv) begin
          kcnt <= (kcnt == KW'(acc_kij - 1)) ? '0 : kcnt + KW'(1);
          if (!last_prod) begin
            acc <= sum;
            cnt <= cnt + CW'(1);
          end else begin
            acc <= '0;
            cnt <= '0;
          end
        end
      end
      // Write and drain target different banks whenever both fire together.
      if (bank_wr) begin
        bank[tail] <= result;
        full[tail] <= 1'b1;
        tail       <= ~tail;
      end
      if (xfer) begin
        full[head] <= 1'b0;
        head       <= ~head;
      end
    end
  end

endmodule

// File: tb/tb_mac_tile_cfg.sv
// Directed self-checking bench for mac_tile_cfg (default parameters).
module tb_mac_tile_cfg;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [3:0]  in_w;
  logic [15:0] in_n;
  logic [1:0]  inst_w;
  logic [3:0]  out_e;
  logic [1:0]  inst_e;
  logic [15:0] out_s;
  logic        ififo_loop;
  logic [15:0] os_out;
  logic        os_out_valid;
  logic        os_out_ready;
  logic        out_stall;

  int vectors = 0;
  int miscompares = 0;

  mac_tile_cfg #(.bw(4), .psum_bw(16), .acc_kij(9), .input_ch(3), .relu_en(1)) dut (
    .clk(clk), .reset(reset), .mode(mode), .in_w(in_w), .in_n(in_n),
    .inst_w(inst_w), .out_e(out_e), .inst_e(inst_e), .out_s(out_s),
    .ififo_loop(ififo_loop), .os_out(os_out), .os_out_valid(os_out_valid),
    .os_out_ready(os_out_ready), .out_stall(out_stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic os_steps(input int n, input logic [3:0] a, input logic [3:0] w);
    for (int i = 0; i < n; i++) begin
      inst_w = 2'b10;
      in_w   = a;
      in_n   = {12'h000, w};
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; mode = 1'b0; in_w = '0; in_n = '0; inst_w = '0; os_out_ready = 1'b0;
    tick(); tick();
    vectors++;
    if ({out_e, inst_e, out_s} !== 22'd0) begin
      miscompares++;
      $display("FAIL reset_ws_outputs: got out_e=%0d inst_e=%0d out_s=%0d expected 0", out_e, inst_e, out_s);
    end
    vectors++;
    if ({ififo_loop, os_out, os_out_valid, out_stall} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_os_outputs: got loop=%0b os_out=%0d valid=%0b stall=%0b expected 0",
               ififo_loop, os_out, os_out_valid, out_stall);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ws_load_exec();
    mode = 1'b0;
    inst_w = 2'b01; in_w = 4'd5; in_n = 16'd0;
    tick();
    vectors++;
    if (inst_e !== 2'b00 || out_s !== 16'd25) begin
      miscompares++;
      $display("FAIL ws_load: got inst_e=%b out_s=%0d expected 00 25", inst_e, out_s);
    end
    inst_w = 2'b10; in_w = 4'd3; in_n = 16'd100;
    tick();
    vectors++;
    if (out_s !== 16'd115) begin
      miscompares++;
      $display("FAIL ws_exec_out_s: got %0d expected 115", out_s);
    end
    vectors++;
    if (out_e !== 4'd3 || inst_e !== 2'b10) begin
      miscompares++;
      $display("FAIL ws_exec_fwd: got out_e=%0d inst_e=%b expected 3 10", out_e, inst_e);
    end
    inst_w = 2'b01; in_w = 4'd7; in_n = 16'd0;
    tick();
    vectors++;
    if (inst_e !== 2'b01 || out_s !== 16'd35) begin
      miscompares++;
      $display("FAIL ws_second_load_fwd: got inst_e=%b out_s=%0d expected 01 35", inst_e, out_s);
    end
    inst_w = 2'b00; in_w = 4'd9; in_n = 16'd4;
    tick();
    vectors++;
    if (out_e !== 4'd7 || inst_e !== 2'b00 || out_s !== 16'd39) begin
      miscompares++;
      $display("FAIL ws_idle_hold: got out_e=%0d inst_e=%b out_s=%0d expected 7 00 39", out_e, inst_e, out_s);
    end
  endtask

  task automatic test_os_default();
    int pulses = 0;
    int bad_pos = 0;
    mode = 1'b1; os_out_ready = 1'b0;
    for (int i = 0; i < 27; i++) begin
      inst_w = 2'b10; in_w = 4'd2; in_n = 16'h000F;
      tick();
      if (ififo_loop === 1'b1) pulses++;
      if (ififo_loop !== ((i % 9) == 8)) bad_pos++;
    end
    inst_w = 2'b00;
    vectors++;
    if (pulses !== 3 || bad_pos !== 0) begin
      miscompares++;
      $display("FAIL os_ififo_loop: got %0d pulses (%0d misplaced) expected 3 (0)", pulses, bad_pos);
    end
    vectors++;
    if (os_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL os_default_early: got valid=%0b at t+1 expected 0", os_out_valid);
    end
    tick();
    vectors++;
    if (os_out_valid !== 1'b1 || os_out !== 16'd0) begin
      miscompares++;
      $display("FAIL os_default_relu: got valid=%0b os_out=%0d expected 1 0", os_out_valid, os_out);
    end
    os_out_ready = 1'b1;
    tick();
    os_out_ready = 1'b0;
    vectors++;
    if (os_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL os_default_drain: got valid=%0b expected 0", os_out_valid);
    end
  endtask

  task automatic test_os_positive();
    os_out_ready = 1'b0;
    os_steps(27, 4'd15, 4'd7);
    inst_w = 2'b00;
    tick();
    vectors++;
    if (os_out_valid !== 1'b1 || os_out !== 16'd2835) begin
      miscompares++;
      $display("FAIL os_pos_value: got valid=%0b os_out=%0d expected 1 2835", os_out_valid, os_out);
    end
    tick(); tick();
    vectors++;
    if (os_out_valid !== 1'b1 || os_out !== 16'd2835) begin
      miscompares++;
      $display("FAIL os_pos_hold: got valid=%0b os_out=%0d expected 1 2835", os_out_valid, os_out);
    end
    os_out_ready = 1'b1;
    tick();
    os_out_ready = 1'b0;
    vectors++;
    if (os_out_valid !== 1'b0 || os_out !== 16'd0) begin
      miscompares++;
      $display("FAIL os_pos_drain: got valid=%0b os_out=%0d expected 0 0", os_out_valid, os_out);
    end
  endtask

  task automatic test_backpressure();
    int stall_bad = 0;
    os_out_ready = 1'b0;
    os_steps(27, 4'd1, 4'd1);
    os_steps(27, 4'd2, 4'd1);
    vectors++;
    if (out_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall_early: got %0b expected 0", out_stall);
    end
    os_steps(1, 4'd3, 4'd1);
    vectors++;
    if (out_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stall_rise: got %0b expected 1", out_stall);
    end
    for (int i = 0; i < 5; i++) begin
      inst_w = 2'b10; in_w = 4'd9; in_n = 16'd1;
      tick();
      if (out_stall !== 1'b1) stall_bad++;
    end
    vectors++;
    if (stall_bad !== 0 || os_out !== 16'd27) begin
      miscompares++;
      $display("FAIL bp_stall_hold: got %0d unstalled cycles head=%0d expected 0 27", stall_bad, os_out);
    end
    inst_w = 2'b00; os_out_ready = 1'b1;
    tick();
    vectors++;
    if (out_stall !== 1'b0 || os_out_valid !== 1'b1 || os_out !== 16'd54) begin
      miscompares++;
      $display("FAIL bp_drain_first: got stall=%0b valid=%0b os_out=%0d expected 0 1 54",
               out_stall, os_out_valid, os_out);
    end
    tick();
    os_out_ready = 1'b0;
    vectors++;
    if (os_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_drain_second: got valid=%0b expected 0", os_out_valid);
    end
    os_steps(26, 4'd3, 4'd1);
    inst_w = 2'b00;
    tick();
    vectors++;
    if (os_out_valid !== 1'b1 || os_out !== 16'd81) begin
      miscompares++;
      $display("FAIL bp_third_result: got valid=%0b os_out=%0d expected 1 81", os_out_valid, os_out);
    end
    os_out_ready = 1'b1;
    tick();
    os_out_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    os_out_ready = 1'b0;
    os_steps(27, 4'd1, 4'd2);
    inst_w = 2'b00;
    tick();
    vectors++;
    if (os_out_valid !== 1'b1 || os_out !== 16'd54) begin
      miscompares++;
      $display("FAIL sim_first_result: got valid=%0b os_out=%0d expected 1 54", os_out_valid, os_out);
    end
    os_steps(27, 4'd1, 4'd3);
    inst_w = 2'b00; os_out_ready = 1'b1;
    tick();
    vectors++;
    if (out_stall !== 1'b0 || os_out_valid !== 1'b1 || os_out !== 16'd81) begin
      miscompares++;
      $display("FAIL sim_write_drain: got stall=%0b valid=%0b os_out=%0d expected 0 1 81",
               out_stall, os_out_valid, os_out);
    end
    tick();
    os_out_ready = 1'b0;
    vectors++;
    if (os_out_valid !== 1'b0 || out_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_final_drain: got valid=%0b stall=%0b expected 0 0", os_out_valid, out_stall);
    end
  endtask

  task automatic test_async_reset();
    os_out_ready = 1'b0;
    os_steps(27, 4'd1, 4'd1);
    os_steps(13, 4'd5, 4'd1);
    #2;
    reset = 1'b0;
    inst_w = 2'b00;
    #1;
    vectors++;
    if ({out_e, inst_e, out_s, ififo_loop, os_out, os_out_valid, out_stall} !== 41'd0) begin
      miscompares++;
      $display("FAIL async_reset_outputs: got out_e=%0d inst_e=%b out_s=%0d os_out=%0d valid=%0b stall=%0b expected 0",
               out_e, inst_e, out_s, os_out, os_out_valid, out_stall);
    end
    tick();
    reset = 1'b1;
    os_steps(27, 4'd4, 4'd2);
    inst_w = 2'b00;
    tick();
    vectors++;
    if (os_out_valid !== 1'b1 || os_out !== 16'd216) begin
      miscompares++;
      $display("FAIL async_reset_clean: got valid=%0b os_out=%0d expected 1 216", os_out_valid, os_out);
    end
    os_out_ready = 1'b1;
    tick();
    os_out_ready = 1'b0;
    vectors++;
    if (os_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_single: got valid=%0b expected 0", os_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_ws_load_exec();
    test_os_default();
    test_os_positive();
    test_backpressure();
    test_simultaneous();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_tile_cfg.md
# mac_tile_cfg

Parametrised, dual-mode (weight-stationary / output-stationary) processing element for the configurable 2D systolic array. It replaces the fixed 4-bit, 9×3-accumulation tile with generic operand and psum widths and a configurable kernel size and channel count. It adds optional ReLU, a two-entry output bank with valid/ready drain to the OFIFO, and a stall output for upstream backpressure. One instance sits at each array coordinate; `out_e`/`inst_e` feed the east neighbour and `out_s` feeds the south neighbour.

## Interface
Parameters:
- `bw`, 4: activation/weight width. Activation is unsigned; weight is two's-complement.
- `psum_bw`, 16: psum/accumulator width, signed; must be ≥ 2·bw.
- `acc_kij`, 9: products per input channel (kernel positions).
- `input_ch`, 3: input channels per output; N = acc_kij·input_ch, with N ≥ 2.
- `relu_en`, 1: 1 = clamp negative final results to 0 in OS mode.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock.
- `mode`  in  1  0 = weight stationary (WS), 1 = output stationary (OS).
- `in_w`  in  bw  activation from the west.
- `in_n`  in  psum_bw  WS: psum from the north; OS: weight in `[bw-1:0]`.
- `inst_w`  in  2  [1] execute, [0] kernel load.
- `out_e`  out  bw  registered activation to the east.
- `inst_e`  out  2  registered instruction to the east.
- `out_s`  out  psum_bw  WS: MAC result; OS: registered weight, zero-extended.
- `ififo_loop`  out  1  one-cycle pulse each time acc_kij products have been accumulated.
- `os_out`  out  psum_bw  head output bank; 0 when `os_out_valid`=0.
- `os_out_valid`  out  1  head bank holds a result.
- `os_out_ready`  in  1  OFIFO accepts `os_out`.
- `out_stall`  out  1  both banks are full; the tile ignores execute steps.

## Operation
- Reset (`reset`=0, async): every register is cleared, `load_ready`=1, both banks are empty, head=0. All outputs are 0.
- WS mode:
  - `inst_q[1]` <= `inst_w[1]`; `c_q` <= `in_n` every cycle.
  - `a_q` <= `in_w` when `inst_w`≠00.
  - If `inst_w[0]` and `load_ready`: `b_q` <= `in_w` and `load_ready` <= 0.
  - `inst_q[0]` <= `inst_w[0]` only while `load_ready`=0, so the first load word is consumed and later ones are forwarded.
  - `out_s` = `a_q`·`b_q` + `c_q`. This is combinational from registers; the product is sign-aware (unsigned act × signed weight) and wraps mod 2^psum_bw.
- OS mode:
  - Step definition: a step is a cycle with `inst_w[1]`=1 and `out_stall`=0.
  - On a step: `a_q` <= `in_w`, `b_q` <= `in_n[bw-1:0]`, `pv` <= 1. `pv` is 0 on any other cycle.
  - `inst_q[1]` <= `inst_w[1]` every cycle. Neighbours see `out_stall` through the array-level stall OR.
  - Cycle after a step (`pv`=1): p = `a_q`·`b_q`.
    - If `cnt` < N-1: `acc` <= `acc`+p and `cnt`++.
    - Else: r = `acc`+p, ReLU applied if `relu_en`. r is written to the tail bank, that bank is marked full, the tail toggles, and `acc` and `cnt` are cleared.
  - `kcnt` counts products mod acc_kij. When it wraps, `ififo_loop`=1 for that one cycle.
- Output drain:
  - Transfer occurs when `os_out_valid`&&`os_out_ready`. It clears the head bank's full flag and toggles the head.
  - A write to one bank and a drain of the other in the same cycle are both honoured.
  - `out_stall` = both banks full.
- Mode change:
  - Legal only with `pv`=0 and `cnt`=0. Filled banks persist and stay drainable.
  - Switching to WS clears `acc`, `cnt` and `kcnt`.

## Timing
- WS: `out_e`/`inst_e` have 1-cycle latency. `out_s` is valid the cycle after the operands are captured.
- OS: the final step at cycle t gives `os_out_valid`=1 at t+2, provided the head bank was empty.
- `ififo_loop` pulses at t+1 after every acc_kij-th step.
- Backpressure: `out_stall` rises the cycle after the second bank fills. It falls the cycle after a transfer.
- A final write into a full bank cannot occur: N ≥ 2 guarantees a stall before it would happen.
- Reset mid-accumulation discards `acc`, `cnt` and both banks, with no partial output.

## Test plan
- WS load then execute:
  - Stimulus: `inst_w`=01, `in_w`=5; then `inst_w`=10, `in_w`=3, `in_n`=100.
  - Response: `b_q`=5, `out_s`=115. The second load word is forwarded on `inst_e[0]`.
- OS default (9×3):
  - Stimulus: 27 steps of act=2, weight=-1.
  - Response: result -54 with `relu_en`=1 gives `os_out`=0, valid at step27+2. `ififo_loop` pulses 3 times.
- OS positive:
  - Stimulus: 27 steps of act=15, weight=7.
  - Response: `os_out`=2835. It is held until `os_out_ready`=1, then `os_out_valid` drops the next cycle.
- Backpressure:
  - Stimulus: `os_out_ready`=0 while 3 outputs' worth of steps are issued.
  - Response: `out_stall`=1 after the second result and steps are ignored. Raising ready drains 2 results in order; the third completes after the stall releases.
- Simultaneous write/drain:
  - Stimulus: a final product arrives in the same cycle the head bank is drained.
  - Response: both banks are correct, no loss, `out_stall` stays 0.
- Async reset:
  - Stimulus: assert `reset`=0 mid-clock at step 13.
  - Response: all outputs are 0 immediately. The next 27 steps produce a clean single result.
